// File: rtl/sram_pkg.sv
// Shared types and helpers for the CPU-bus to 8-bit asynchronous SRAM bridge.
package sram_pkg;

  typedef enum logic [1:0] {
    ACC_B   = 2'd0,
    ACC_H   = 2'd1,
    ACC_W   = 2'd2,
    ACC_RSV = 2'd3
  } acc_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_ACCESS,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

  function automatic logic [2:0] acc_bytes(input acc_e acc);
    case (acc)
      ACC_B:   acc_bytes = 3'd1;
      ACC_H:   acc_bytes = 3'd2;
      ACC_W:   acc_bytes = 3'd4;
      default: acc_bytes = 3'd0;
    endcase
  endfunction

  // Reserved sizes are reported through the same error path as misalignment.
  function automatic logic misaligned(input acc_e acc, input logic [1:0] addr_lo);
    case (acc)
      ACC_B:   misaligned = 1'b0;
      ACC_H:   misaligned = addr_lo[0];
      ACC_W:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits 32-bit bus accesses into byte cycles on an 8-bit asynchronous SRAM
// with programmable OE/WE strobe widths.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int T_RD = 2,
  parameter int T_WR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_w_rb,
  input  logic [1:0]  bus_acc,
  input  logic [18:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_resp,
  output logic        bus_err,
  output logic        busy,
  output logic        sram_ce_bar,
  output logic        sram_oe_bar,
  output logic        sram_we_bar,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe,
  input  logic [7:0]  sram_data_i
);

  localparam int T_MAX = (T_RD > T_WR) ? T_RD : T_WR;
  localparam int CNT_W = $clog2(T_MAX) + 1;

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [1:0]       last_idx;
  logic             err;
  logic [18:0]      base;
  logic [31:0]      wbuf;
  logic [31:0]      rbuf;
  logic [31:0]      rd_merged;
  logic [2:0]       req_bytes;
  logic             req_bad;
  logic             accept;
  logic             rd_cnt_done;
  logic             wr_cnt_done;
  logic             byte_last;
  logic             byte_step;
  logic             sram_sel;

  always_comb begin
    req_bytes   = acc_bytes(acc_e'(bus_acc));
    req_bad     = misaligned(acc_e'(bus_acc), bus_addr[1:0]);
    accept      = (state == IDLE) && bus_req;
    rd_cnt_done = (cnt == CNT_W'(T_RD - 1));
    wr_cnt_done = (cnt == CNT_W'(T_WR - 1));
    byte_last   = (idx == last_idx);
    byte_step   = !byte_last &&
                  (((state == RD_ACCESS) && rd_cnt_done) || (state == WR_HOLD));
  end

  // Final read data is the buffer with the byte arriving on this edge merged in.
  always_comb begin
    rd_merged = rbuf;
    rd_merged[{idx, 3'b000} +: 8] = sram_data_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus_req) begin
          if (req_bad)       state_nx = DONE;
          else if (bus_w_rb) state_nx = WR_SETUP;
          else               state_nx = RD_SETUP;
        end
      end
      RD_SETUP:  state_nx = RD_ACCESS;
      RD_ACCESS: if (rd_cnt_done) state_nx = byte_last ? DONE : RD_SETUP;
      WR_SETUP:  state_nx = WR_PULSE;
      WR_PULSE:  if (wr_cnt_done) state_nx = WR_HOLD;
      WR_HOLD:   state_nx = byte_last ? DONE : WR_SETUP;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      err       <= 1'b0;
      bus_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == state) ? cnt + 1'b1 : '0;
      if (accept) begin
        idx <= '0;
        err <= req_bad;
      end else if (byte_step) begin
        idx <= idx + 2'd1;
      end
      // Result only changes on entry to DONE so it stays stable between responses.
      if ((state_nx == DONE) && (state != DONE))
        bus_rdata <= (state == RD_ACCESS) ? rd_merged : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base     <= bus_addr;
      wbuf     <= bus_wdata;
      rbuf     <= '0;
      last_idx <= 2'(req_bytes - 3'd1);
    end else if ((state == RD_ACCESS) && rd_cnt_done) begin
      rbuf[{idx, 3'b000} +: 8] <= sram_data_i;
    end
  end

  always_comb begin
    sram_sel     = (state == RD_SETUP) || (state == RD_ACCESS) ||
                   (state == WR_SETUP) || (state == WR_PULSE)  || (state == WR_HOLD);
    sram_data_oe = (state == WR_SETUP) || (state == WR_PULSE)  || (state == WR_HOLD);
    sram_ce_bar  = !sram_sel;
    sram_oe_bar  = (state != RD_ACCESS);
    sram_we_bar  = (state != WR_PULSE);
    sram_addr    = sram_sel ? (base + 19'(idx)) : '0;
    sram_data_o  = sram_data_oe ? wbuf[{idx, 3'b000} +: 8] : '0;
    bus_resp     = (state == DONE);
    bus_err      = (state == DONE) && err;
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: behavioural SRAM on the pins, reference byte
// array updated per request, and an independent monitor checking every response.
module tb_sram_ctrl;

  localparam int T_RD = 2;
  localparam int T_WR = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_w_rb = 1'b0;
  logic [1:0]  bus_acc = 2'd0;
  logic [18:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_resp, bus_err, busy;
  logic        sram_ce_bar, sram_oe_bar, sram_we_bar;
  logic [18:0] sram_addr;
  logic [7:0]  sram_data_o;
  logic        sram_data_oe;
  logic [7:0]  sram_data_i;

  sram_ctrl #(.T_RD(T_RD), .T_WR(T_WR)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_resp(bus_resp), .bus_err(bus_err), .busy(busy),
    .sram_ce_bar(sram_ce_bar), .sram_oe_bar(sram_oe_bar), .sram_we_bar(sram_we_bar),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin-level SRAM model and the bench's own reference copy of memory.
  logic [7:0] sram_mem [0:(1<<19)-1];
  logic [7:0] ref_mem  [0:(1<<19)-1];

  always @(posedge clk)
    if (!sram_ce_bar && !sram_we_bar && sram_data_oe) sram_mem[sram_addr] <= sram_data_o;

  assign sram_data_i = (!sram_ce_bar && !sram_oe_bar) ? sram_mem[sram_addr] : 8'hA5;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pad-contention rule every cycle, scoreboard pop on every response.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!sram_oe_bar && sram_data_oe) begin
        errors++;
        $display("FAIL pad_contention: oe_bar=0 while data_oe=1 at cycle %0d", cyc);
      end
      if (bus_resp) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: bus_resp at cycle %0d with no request outstanding", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", bus_rdata & e.mask, e.rdata & e.mask);
          chk("err", 32'(bus_err), 32'(e.err));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("busy_at_resp", 32'(busy), 32'd1);
          if (e.err) chk("ce_idle_on_err", 32'(sram_ce_bar), 32'd1);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL %s: busy stuck high, got 1 expected 0", name);
        break;
      end
    end
  endtask

  // Issue one request at a negedge; the reference model derives the response.
  task automatic issue(input bit w, input logic [1:0] acc, input logic [18:0] addr,
                       input logic [31:0] wd, input logic [31:0] mask);
    exp_t e;
    int n;
    bit bad;
    wait_idle("issue_wait");
    n   = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
    bad = (acc == 2'd3) || (acc == 2'd1 && addr[0]) || (acc == 2'd2 && addr[1:0] != 2'b00);
    e.rdata = '0;
    e.mask  = mask;
    e.err   = bad;
    e.t0    = cyc;
    if (bad) begin
      e.lat = 1;
    end else if (w) begin
      e.lat = n * (T_WR + 2) + 1;
      for (int k = 0; k < n; k++) ref_mem[addr + 19'(k)] = wd[8*k +: 8];
    end else begin
      e.lat = n * (T_RD + 1) + 1;
      for (int k = 0; k < n; k++) e.rdata[8*k +: 8] = ref_mem[addr + 19'(k)];
    end
    sb.push_back(e);
    bus_req = 1'b1; bus_w_rb = w; bus_acc = acc; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    bus_req = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    wait_idle("drain_idle");
  endtask

  initial begin
    for (int i = 0; i < (1 << 19); i++) begin
      sram_mem[i] = 8'(i * 37 + 11);
      ref_mem[i]  = 8'(i * 37 + 11);
    end

    repeat (3) @(negedge clk);
    chk("rst_ce_bar", 32'(sram_ce_bar), 32'd1);
    chk("rst_oe_bar", 32'(sram_oe_bar), 32'd1);
    chk("rst_we_bar", 32'(sram_we_bar), 32'd1);
    chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_resp", 32'(bus_resp), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_data_o", 32'(sram_data_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the test plan.
    issue(1'b1, 2'd2, 19'h00100, 32'h44332211, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, 19'h00100, 32'h0, 32'hFFFFFFFF);
    issue(1'b0, 2'd0, 19'h00103, 32'h0, 32'hFFFFFFFF);
    issue(1'b0, 2'd1, 19'h00102, 32'h0, 32'hFFFFFFFF);
    issue(1'b0, 2'd1, 19'h00101, 32'h0, 32'hFFFFFFFF);
    issue(1'b1, 2'd2, 19'h00102, 32'hCAFEF00D, 32'hFFFFFFFF);
    issue(1'b0, 2'd3, 19'h00100, 32'h0, 32'hFFFFFFFF);
    issue(1'b1, 2'd2, 19'h7FFFC, 32'h8899AABB, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, 19'h7FFFC, 32'h0, 32'hFFFFFFFF);
    drain();
    chk("mem_0x100", {sram_mem[19'h103], sram_mem[19'h102], sram_mem[19'h101], sram_mem[19'h100]},
        32'h44332211);

    // A request while busy must be dropped entirely.
    issue(1'b1, 2'd2, 19'h00140, 32'hDEADBEEF, 32'hFFFFFFFF);
    @(negedge clk);
    bus_req = 1'b1; bus_w_rb = 1'b1; bus_acc = 2'd2; bus_addr = 19'h00140; bus_wdata = 32'h12345678;
    @(negedge clk);
    bus_req = 1'b0;
    issue(1'b0, 2'd2, 19'h00140, 32'h0, 32'hFFFFFFFF);
    drain();

    // Reset during the WE pulse of byte 1 of a word write.
    bus_req = 1'b1; bus_w_rb = 1'b1; bus_acc = 2'd2; bus_addr = 19'h00200; bus_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    bus_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_we_low", 32'(sram_we_bar), 32'd0);
    chk("midrst_addr", 32'(sram_addr), 32'h00201);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we_bar", 32'(sram_we_bar), 32'd1);
    chk("midrst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("midrst_ce_bar", 32'(sram_ce_bar), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp", 32'(bus_resp), 32'd0);
    rst = 1'b0;
    ref_mem[19'h00200] = 8'hD4;
    @(negedge clk);
    issue(1'b0, 2'd2, 19'h00200, 32'h0, 32'hFFFF00FF);
    drain();

    // Randomized traffic over a low window and the top of memory.
    for (int t = 0; t < 250; t++) begin
      logic [18:0] a;
      a = ($urandom_range(0, 3) == 0) ? 19'h7FF00 + 19'($urandom_range(0, 255))
                                      : 19'h00100 + 19'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 32'hFFFFFFFF);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bridges the internal 32-bit CPU data bus to the board's external 8-bit asynchronous SRAM (512 KiB, 19-bit byte address, active-low CE/OE/WE).
- Splits each byte, halfword or word access into sequential byte cycles with programmable strobe timing.
- Sits inside the FPGA top between the bus decoder and the wrapper's SRAM pins.
- The wrapper owns the bidirectional sram_data tristate.

Parameters:
- T_RD, 2: cycles OE is held low per read byte before data capture (≥1).
- T_WR, 1: cycles WE is held low per write byte (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- bus_req  input  1  single-cycle request pulse
- bus_w_rb  input  1  1 = write, 0 = read
- bus_acc  input  2  size: 0 = byte, 1 = halfword, 2 = word, 3 = reserved
- bus_addr  input  19  byte address
- bus_wdata  input  32  write data, little-endian
- bus_rdata  output  32  read data, valid while bus_resp = 1
- bus_resp  output  1  one-cycle completion pulse
- bus_err  output  1  qualifies bus_resp: misaligned or reserved access
- busy  output  1  high from the cycle after an accepted req until the bus_resp cycle inclusive
- sram_ce_bar  output  1  chip enable
- sram_oe_bar  output  1  output enable
- sram_we_bar  output  1  write enable
- sram_addr  output  19  SRAM byte address
- sram_data_o  output  8  write data to pads
- sram_data_oe  output  1  pad drive enable
- sram_data_i  input  8  read data from pads

Behaviour:
- Reset (synchronous, any state): next edge → IDLE. Outputs:
  - ce/oe/we_bar = 1
  - sram_data_oe = 0
  - bus_resp = 0, bus_err = 0, busy = 0
  - bus_rdata = 0, sram_addr = 0, sram_data_o = 0
  - A reset mid-transaction aborts it with no bus_resp.
- Byte count N:
  - N = 1 / 2 / 4 for acc = 0 / 1 / 2.
  - Byte k uses address bus_addr+k and data lane [8k+:8].
- Errors (acc = 3, halfword with addr[0] = 1, word with addr[1:0] ≠ 0):
  - No SRAM cycle.
  - Next cycle: bus_resp = 1, bus_err = 1, bus_rdata = 0.
- bus_req while busy = 1 is ignored; no state or output change.
- Request capture: in IDLE, req latches w_rb, acc, addr, wdata and resets byte index k = 0.
- States: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- RD_SETUP (1 cycle):
  - sram_addr = base+k, ce_bar = 0, oe_bar = 1, we_bar = 1.
  - → RD_ACCESS.
- RD_ACCESS (T_RD cycles):
  - oe_bar = 0.
  - At the edge ending the last cycle, capture sram_data_i into rdata[8k+:8].
  - If k = N−1 → DONE, else k+1 → RD_SETUP.
- WR_SETUP (1 cycle):
  - sram_addr = base+k, sram_data_o = wdata[8k+:8], data_oe = 1, ce_bar = 0, we_bar = 1.
  - → WR_PULSE.
- WR_PULSE (T_WR cycles): we_bar = 0; address and data stable.
- WR_HOLD (1 cycle):
  - we_bar = 1; address and data still driven; ce_bar = 0.
  - If k = N−1 → DONE, else k+1 → WR_SETUP.
- Pad drive:
  - data_oe = 1 only in WR_SETUP, WR_PULSE and WR_HOLD.
  - oe_bar is never 0 while data_oe = 1.
- DONE (1 cycle):
  - ce/oe/we_bar = 1, data_oe = 0, bus_resp = 1, bus_err = 0.
  - bus_rdata holds the captured bytes, with unused upper lanes = 0; 0 for writes.
  - → IDLE.
- Latency from req cycle to bus_resp cycle:
  - read: N·(T_RD+1)+1
  - write: N·(T_WR+2)+1
  - error: 1
- A new req is accepted the cycle after DONE (back-to-back allowed).
- Address arithmetic: 19-bit, no carry out. An aligned access never crosses the top of memory.
- bus_rdata is held until the next transaction's DONE.

Decomposition:
- Package sram_pkg:
  - access-size enum (ACC_B, ACC_H, ACC_W, ACC_RSV)
  - state enum
  - function acc_bytes(acc) returning N
  - function misaligned(acc, addr)
- No sub-module. A single FSM with a wait counter (width $clog2(max(T_RD,T_WR))+1) and a 2-bit byte index is natural.

Test Plan:
- Word write at 0x00100, wdata = 0x44332211, T_WR = 1:
  - 4 WE pulses of 1 cycle; SRAM bytes 0x100..0x103 = 11,22,33,44.
  - bus_resp at cycle 13, bus_err = 0.
- Word read of 0x00100 after the above, T_RD = 2:
  - bus_rdata = 0x44332211.
  - bus_resp at cycle 13; oe_bar never low while data_oe = 1.
- Byte read at 0x00103 → bus_rdata = 0x00000044. Halfword read at 0x00102 → bus_rdata = 0x00004433, bus_resp at cycle 7.
- Halfword at 0x00101 and word at 0x00102:
  - bus_resp and bus_err at cycle 1; ce_bar stays 1 throughout.
  - acc = 3 produces the same response.
- Second bus_req during a word write: ignored, no extra bus_resp; the SRAM contents match the first request only.
- rst asserted during WR_PULSE of byte 1: next cycle IDLE, we_bar = 1, data_oe = 0, no bus_resp. A following word read at the same address returns byte 0 written and bytes 2..3 unchanged.
